pipe_hazard_ctrl: RTL and testbench

Parametrised hazard, forwarding and stall/flush controller for the in-order RISC-V pipeline. It replaces the fixed two-source forwarding unit and the single-cycle load-use detector. The block keeps its own shadow scoreboard of the post-ID stages and supports:
- configurable post-ID depth and load latency,
- a multi-cycle MDU with start/done handshake,
- data-memory wait states,
- branch redirect flushes.

It drives per-register enable/flush vectors, EX operand forward selects and performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall/flush controller for the in-order pipeline.
// Keeps a shadow copy of the post-ID stages S[0]=EX .. S[D-1]=WB and, from
// that, derives per-register enables/flushes, EX forward selects, the MDU
// start/busy handshake and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int RF_ADDRESS = 5,
  parameter int D          = 3,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = $clog2(D)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [RF_ADDRESS-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_is_load,
  input  logic                  id_is_mem,
  input  logic                  id_is_mdu,
  input  logic                  ex_taken,
  input  logic                  mdu_done,
  input  logic                  mem_ready,
  output logic [D:0]            stage_en,
  output logic [D:0]            stage_flush,
  output logic [SEL_W-1:0]      fwd_a,
  output logic [SEL_W-1:0]      fwd_b,
  output logic                  mdu_start,
  output logic                  mdu_busy,
  output logic [CNT_W-1:0]      cnt_stall,
  output logic [CNT_W-1:0]      cnt_flush
);

  typedef struct packed {
    logic                  valid;
    logic [RF_ADDRESS-1:0] rs1;
    logic [RF_ADDRESS-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
    logic [RF_ADDRESS-1:0] rd;
    logic                  regwrite;
    logic                  load;
    logic                  mem;
    logic                  mdu;
  } entry_t;

  entry_t stg     [D];
  entry_t stg_nxt [D];
  entry_t id_entry;

  logic mem_stall;
  logic mdu_stall;
  logic redirect;
  logic load_use;
  logic hazard;
  logic s0_advance;

  // Pack the ID-stage fields into a shadow entry.
  always_comb begin
    id_entry          = '0;
    id_entry.valid    = id_valid;
    id_entry.rs1      = id_rs1;
    id_entry.rs2      = id_rs2;
    id_entry.use_rs1  = id_use_rs1;
    id_entry.use_rs2  = id_use_rs2;
    id_entry.rd       = id_rd;
    id_entry.regwrite = id_regwrite;
    id_entry.load     = id_is_load;
    id_entry.mem      = id_is_mem;
    id_entry.mdu      = id_is_mdu;
  end

  // Load-use: an ID source matches a load still too young to forward.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (stg[i].valid && stg[i].load && (stg[i].rd != '0) &&
          ((id_use_rs1 && (id_rs1 == stg[i].rd)) ||
           (id_use_rs2 && (id_rs2 == stg[i].rd))))
        hazard = 1'b1;
    end
  end

  assign mem_stall = stg[1].valid & stg[1].mem & ~mem_ready;
  assign mdu_stall = ~mem_stall & stg[0].valid & stg[0].mdu & ~(mdu_busy & mdu_done);
  assign redirect  = ex_taken & ~mem_stall & ~mdu_stall;
  assign load_use  = ~mem_stall & ~mdu_stall & ~ex_taken & id_valid & hazard;

  // Prioritised enable/flush generation; reset forces every register to a bubble.
  always_comb begin
    stage_en    = '1;
    stage_flush = '0;
    if (reset) begin
      stage_flush = '1;
    end else if (mem_stall) begin
      stage_en[2:0]  = '0;
      stage_flush[3] = 1'b1;
    end else if (mdu_stall) begin
      stage_en[1:0]  = '0;
      stage_flush[2] = 1'b1;
    end else if (redirect) begin
      stage_flush[1:0] = 2'b11;
    end else if (load_use) begin
      stage_en[0]    = 1'b0;
      stage_flush[1] = 1'b1;
    end
  end

  // Youngest producer wins, so scan from WB toward EX and let the later hit override.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (!reset) begin
      for (int k = D - 1; k >= 1; k--) begin
        if (stg[k].valid && stg[k].regwrite && (stg[k].rd != '0)) begin
          if (stg[0].use_rs1 && (stg[k].rd == stg[0].rs1)) fwd_a = SEL_W'(k);
          if (stg[0].use_rs2 && (stg[k].rd == stg[0].rs2)) fwd_b = SEL_W'(k);
        end
      end
    end
  end

  // Next shadow contents: a flush leaves a fully cleared bubble, a disabled stage holds.
  always_comb begin
    for (int k = 0; k < D; k++) stg_nxt[k] = stg[k];
    if (stage_flush[1])   stg_nxt[0] = '0;
    else if (stage_en[1]) stg_nxt[0] = id_entry;
    for (int k = 1; k < D; k++) begin
      if (stage_flush[k+1])   stg_nxt[k] = '0;
      else if (stage_en[k+1]) stg_nxt[k] = stg[k-1];
    end
  end

  // Shadow scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < D; k++) stg[k] <= '0;
    end else begin
      for (int k = 0; k < D; k++) stg[k] <= stg_nxt[k];
    end
  end

  assign s0_advance = stage_en[2] & ~stage_flush[2];
  assign mdu_start  = ~reset & stg[0].valid & stg[0].mdu & ~mdu_busy;

  // MDU busy flag: set after the launch pulse, cleared when the result leaves EX.
  always_ff @(posedge clk) begin
    if (reset)                                    mdu_busy <= 1'b0;
    else if (mdu_start)                           mdu_busy <= 1'b1;
    else if (mdu_busy && mdu_done && s0_advance)  mdu_busy <= 1'b0;
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else begin
      if (!stage_en[0] && (cnt_stall != '1))   cnt_stall <= cnt_stall + 1'b1;
      if (stage_flush[0] && (cnt_flush != '1)) cnt_flush <= cnt_flush + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations (D=3/LOAD_LAT=1/32-bit
// counters and D=4/LOAD_LAT=2/3-bit counters) share one directed stimulus
// stream; a per-configuration pipeline model is checked every cycle and a
// set of hand-computed literals pins the model down.
module tb_pipe_hazard_ctrl;

  logic       clk, reset;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite;
  logic       id_is_load, id_is_mem, id_is_mdu;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_taken, mdu_done, mem_ready;

  logic [3:0]  a_en, a_fl;
  logic [1:0]  a_fwd_a, a_fwd_b;
  logic        a_start, a_busy;
  logic [31:0] a_cs, a_cf;

  logic [4:0]  b_en, b_fl;
  logic [1:0]  b_fwd_a, b_fwd_b;
  logic        b_start, b_busy;
  logic [2:0]  b_cs, b_cf;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_mem(id_is_mem),
    .id_is_mdu(id_is_mdu), .ex_taken(ex_taken), .mdu_done(mdu_done), .mem_ready(mem_ready),
    .stage_en(a_en), .stage_flush(a_fl), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
    .mdu_start(a_start), .mdu_busy(a_busy), .cnt_stall(a_cs), .cnt_flush(a_cf));

  pipe_hazard_ctrl #(.D(4), .LOAD_LAT(2), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_mem(id_is_mem),
    .id_is_mdu(id_is_mdu), .ex_taken(ex_taken), .mdu_done(mdu_done), .mem_ready(mem_ready),
    .stage_en(b_en), .stage_flush(b_fl), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
    .mdu_start(b_start), .mdu_busy(b_busy), .cnt_stall(b_cs), .cnt_flush(b_cf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit v, u1, u2, rw, ld, mem, mdu;
    int rs1, rs2, rd;
  } ent_t;

  ent_t   m [2][4];
  bit     mbusy [2];
  longint mcs [2], mcf [2];
  int     dd [2]   = '{3, 4};
  int     ll [2]   = '{1, 2};
  longint cmax [2] = '{64'hFFFF_FFFF, 7};

  int e_en [2], e_fl [2], e_fa [2], e_fb [2];
  bit e_st [2];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_id(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit rw, input bit ld, input bit mem, input bit mdu);
    id_valid = v;  id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = 5'(rd);
    id_regwrite = rw; id_is_load = ld; id_is_mem = mem; id_is_mdu = mdu;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // What the block must do this cycle, from the stall/flush priority rules.
  task automatic model_eval(input int j);
    int n, allm;
    bit ms, ds, hz;
    n    = dd[j];
    allm = (1 << (n + 1)) - 1;
    ms = m[j][1].v && m[j][1].mem && !mem_ready;
    ds = !ms && m[j][0].v && m[j][0].mdu && !(mbusy[j] && mdu_done);
    hz = 0;
    for (int i = 0; i < ll[j]; i++)
      if (m[j][i].v && m[j][i].ld && m[j][i].rd != 0 &&
          ((id_use_rs1 && int'(id_rs1) == m[j][i].rd) || (id_use_rs2 && int'(id_rs2) == m[j][i].rd)))
        hz = 1;
    if (reset)                   begin e_en[j] = allm;      e_fl[j] = allm; end
    else if (ms)                 begin e_en[j] = allm & ~7; e_fl[j] = 8;    end
    else if (ds)                 begin e_en[j] = allm & ~3; e_fl[j] = 4;    end
    else if (ex_taken)           begin e_en[j] = allm;      e_fl[j] = 3;    end
    else if (id_valid && hz)     begin e_en[j] = allm & ~1; e_fl[j] = 2;    end
    else                         begin e_en[j] = allm;      e_fl[j] = 0;    end
    e_fa[j] = 0;
    e_fb[j] = 0;
    if (!reset) begin
      for (int k = 1; k < n; k++) begin
        if (m[j][k].v && m[j][k].rw && m[j][k].rd != 0) begin
          if (e_fa[j] == 0 && m[j][0].u1 && m[j][k].rd == m[j][0].rs1) e_fa[j] = k;
          if (e_fb[j] == 0 && m[j][0].u2 && m[j][k].rd == m[j][0].rs2) e_fb[j] = k;
        end
      end
    end
    e_st[j] = !reset && m[j][0].v && m[j][0].mdu && !mbusy[j];
  endtask

  // Move the modelled pipeline across one clock edge.
  task automatic model_adv(input int j);
    int n;
    n = dd[j];
    if (reset) begin
      for (int k = 0; k < 4; k++) m[j][k] = '{default: 0};
      mbusy[j] = 0; mcs[j] = 0; mcf[j] = 0;
      return;
    end
    if (e_st[j]) mbusy[j] = 1;
    else if (mbusy[j] && mdu_done && e_en[j][2] && !e_fl[j][2]) mbusy[j] = 0;
    if (!e_en[j][0] && mcs[j] < cmax[j]) mcs[j]++;
    if (e_fl[j][0] && mcf[j] < cmax[j]) mcf[j]++;
    for (int k = n - 1; k >= 0; k--) begin
      if (e_fl[j][k+1]) m[j][k] = '{default: 0};
      else if (e_en[j][k+1]) begin
        if (k == 0) begin
          m[j][0].v = id_valid; m[j][0].rs1 = int'(id_rs1); m[j][0].rs2 = int'(id_rs2);
          m[j][0].u1 = id_use_rs1; m[j][0].u2 = id_use_rs2; m[j][0].rd = int'(id_rd);
          m[j][0].rw = id_regwrite; m[j][0].ld = id_is_load; m[j][0].mem = id_is_mem;
          m[j][0].mdu = id_is_mdu;
        end else begin
          m[j][k] = m[j][k-1];
        end
      end
    end
  endtask

  task automatic eval();
    #2;
    model_eval(0);
    model_eval(1);
    chk("en_a", a_en, e_en[0]);
    chk("flush_a", a_fl, e_fl[0]);
    if (reset || m[0][0].v) begin
      chk("fwd_a_a", a_fwd_a, e_fa[0]);
      chk("fwd_b_a", a_fwd_b, e_fb[0]);
    end
    chk("start_a", a_start, e_st[0]);
    chk("busy_a", a_busy, mbusy[0]);
    chk("cnt_stall_a", a_cs, mcs[0]);
    chk("cnt_flush_a", a_cf, mcf[0]);
    chk("en_b", b_en, e_en[1]);
    chk("flush_b", b_fl, e_fl[1]);
    if (reset || m[1][0].v) begin
      chk("fwd_a_b", b_fwd_a, e_fa[1]);
      chk("fwd_b_b", b_fwd_b, e_fb[1]);
    end
    chk("start_b", b_start, e_st[1]);
    chk("busy_b", b_busy, mbusy[1]);
    chk("cnt_stall_b", b_cs, mcs[1]);
    chk("cnt_flush_b", b_cf, mcf[1]);
  endtask

  task automatic adv();
    model_adv(0);
    model_adv(1);
    @(negedge clk);
  endtask

  task automatic cyc();
    eval();
    adv();
  endtask

  initial begin
    reset = 1; nop(); ex_taken = 0; mdu_done = 0; mem_ready = 1;
    model_eval(0); model_eval(1);
    adv();

    // reset state
    eval();
    chk("lit_rst_en", a_en, 15);  chk("lit_rst_flush", a_fl, 15);
    chk("lit_rst_fwd", a_fwd_a, 0); chk("lit_rst_start", a_start, 0);
    chk("lit_rst_cnt", a_cs, 0);
    adv();
    reset = 0;

    // forwarding: two x5 producers, youngest selected; x0 never forwarded
    set_id(1, 1, 2, 0, 0, 5, 1, 0, 0, 0); cyc();
    set_id(1, 1, 2, 0, 0, 5, 1, 0, 0, 0); cyc();
    set_id(1, 5, 0, 1, 0, 6, 1, 0, 0, 0); cyc();
    nop(); eval(); chk("lit_fwd_youngest_a", a_fwd_a, 1); chk("lit_fwd_youngest_b", b_fwd_a, 1); adv();
    set_id(1, 1, 2, 0, 0, 0, 1, 0, 0, 0); cyc(); cyc();
    set_id(1, 0, 0, 1, 0, 6, 1, 0, 0, 0); cyc();
    nop(); eval(); chk("lit_fwd_x0", a_fwd_a, 0); adv();
    set_id(1, 1, 2, 0, 0, 7, 1, 0, 0, 0); cyc();
    nop(); cyc();
    set_id(1, 5, 7, 1, 1, 9, 1, 0, 0, 0); cyc();
    nop(); eval(); chk("lit_fwd_b_wb", a_fwd_b, 2); chk("lit_fwd_a_none", a_fwd_a, 0); adv();

    // load-use: one stall at LOAD_LAT=1, two at LOAD_LAT=2
    set_id(1, 0, 0, 0, 0, 3, 1, 1, 1, 0); cyc();
    set_id(1, 3, 0, 1, 0, 8, 1, 0, 0, 0);
    eval(); chk("lit_lu_en_a", a_en, 4'b1110); chk("lit_lu_fl_a", a_fl, 4'b0010);
    chk("lit_lu_en_b", b_en, 5'b11110); adv();
    eval(); chk("lit_lu2_en_a", a_en, 15); chk("lit_lu2_en_b", b_en, 5'b11110); adv();
    eval(); chk("lit_lu_fwd_wb_a", a_fwd_a, 2); chk("lit_lu3_en_b", b_en, 31); adv();
    nop(); eval(); chk("lit_lu_fwd_b", b_fwd_a, 3);
    chk("lit_lu_stall_a", a_cs, 1); chk("lit_lu_stall_b", b_cs, 2); adv();
    repeat (4) cyc();

    // MDU op, done four cycles after start
    reset = 1; cyc(); reset = 0;
    set_id(1, 1, 2, 1, 1, 9, 1, 0, 0, 1); cyc();
    nop(); eval(); chk("lit_mdu_start", a_start, 1); chk("lit_mdu_busy0", a_busy, 0);
    chk("lit_mdu_en", a_en, 4'b1100); chk("lit_mdu_fl", a_fl, 4'b0100); adv();
    repeat (3) begin
      eval(); chk("lit_mdu_busy", a_busy, 1); chk("lit_mdu_nostart", a_start, 0);
      chk("lit_mdu_fl_hold", a_fl, 4'b0100); adv();
    end
    mdu_done = 1; eval(); chk("lit_mdu_release_en", a_en, 15); adv();
    mdu_done = 0; eval(); chk("lit_mdu_cnt_a", a_cs, 4); chk("lit_mdu_cnt_b", b_cs, 4);
    chk("lit_mdu_idle", a_busy, 0); adv();

    // store waiting on memory while a MUL sits in EX
    set_id(1, 1, 2, 1, 1, 0, 0, 0, 1, 0); cyc();
    set_id(1, 3, 4, 1, 1, 10, 1, 0, 0, 1); cyc();
    nop(); mem_ready = 0;
    eval(); chk("lit_ms_fl_a", a_fl, 4'b1000); chk("lit_ms_en_a", a_en, 4'b1000);
    chk("lit_ms_fl_b", b_fl, 5'b01000); chk("lit_ms_en_b", b_en, 5'b11000); adv();
    ex_taken = 1; eval(); chk("lit_ms_taken_fl", a_fl, 4'b1000); adv(); ex_taken = 0;
    eval(); chk("lit_ms_fl3", a_fl, 4'b1000); adv();
    mem_ready = 1;
    eval(); chk("lit_ms_then_mdu_fl", a_fl, 4'b0100); chk("lit_ms_then_mdu_en_b", b_en, 5'b11100); adv();
    mdu_done = 1; eval(); chk("lit_ms_release", a_en, 15); adv(); mdu_done = 0;

    // redirect wins over a load-use hazard
    set_id(1, 0, 0, 0, 0, 4, 1, 1, 1, 0); cyc();
    set_id(1, 0, 4, 0, 1, 11, 1, 0, 0, 0); ex_taken = 1;
    eval(); chk("lit_redir_fl_a", a_fl, 4'b0011); chk("lit_redir_en_a", a_en, 15);
    chk("lit_redir_fl_b", b_fl, 5'b00011); adv(); ex_taken = 0;
    nop(); eval(); chk("lit_redir_cnt_a", a_cf, 1); chk("lit_redir_cnt_b", b_cf, 1); adv();

    // reset while the MDU is busy
    set_id(1, 1, 2, 1, 1, 12, 1, 0, 0, 1); cyc();
    nop(); eval(); chk("lit_rm_start", a_start, 1); adv();
    eval(); chk("lit_rm_busy", a_busy, 1); adv();
    reset = 1;
    eval(); chk("lit_rm_rst_en", a_en, 15); chk("lit_rm_rst_fl", a_fl, 15);
    chk("lit_rm_rst_start", a_start, 0); chk("lit_rm_rst_fwd", a_fwd_a, 0); adv();
    reset = 0; set_id(1, 1, 2, 1, 1, 12, 1, 0, 0, 1);
    eval(); chk("lit_rm_busy0", a_busy, 0); chk("lit_rm_cs0", a_cs, 0); chk("lit_rm_cf0", a_cf, 0);
    chk("lit_rm_nostart", a_start, 0); adv();

    // long MDU stall saturates the 3-bit counter
    nop(); repeat (9) cyc();
    mdu_done = 1; cyc(); mdu_done = 0;
    eval(); chk("lit_sat_a", a_cs, 9); chk("lit_sat_b", b_cs, 7); adv();

    // mixed traffic, model-checked every cycle
    for (int n = 0; n < 300; n++) begin
      reset    = ($urandom_range(0, 99) < 2);
      id_valid = $urandom_range(0, 1);
      id_rs1   = 5'($urandom_range(0, 3));
      id_rs2   = 5'($urandom_range(0, 3));
      id_use_rs1 = $urandom_range(0, 1);
      id_use_rs2 = $urandom_range(0, 1);
      id_rd    = 5'($urandom_range(0, 3));
      id_regwrite = $urandom_range(0, 1);
      id_is_load  = ($urandom_range(0, 3) == 0);
      id_is_mem   = id_is_load | ($urandom_range(0, 5) == 0);
      id_is_mdu   = !id_is_mem && ($urandom_range(0, 5) == 0);
      ex_taken    = ($urandom_range(0, 4) == 0);
      mdu_done    = ($urandom_range(0, 2) == 0);
      mem_ready   = ($urandom_range(0, 9) < 7);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
